ledsd_scan_lbus: RTL and testbench
==================================

Name: ledsd_scan_lbus

Overview:
- LBUS slave that time-multiplexes NUM seven-segment digits over one shared 8-line segment bus.
- Holds per-digit data registers, a control register and a 16-bit scan prescaler.
- A scan FSM drives each digit's common line in turn, with an optional blanking gap to suppress ghosting.
- Sits beside the direct-drive LEDSD peripheral on the LBUS and targets boards whose digits share segment pins.

Parameters:
- NUM, 4, number of digits; legal range 1..8.
- COM, 0, polarity: 0 = common cathode (seg active-high, com active-low); 1 = common anode (seg active-low, com active-high).
- BLANK_CYC, 4, lb_clk cycles of all-off between digits; must be >= 1.

Ports:
- lb_clk  in  1  bus/system clock.
- rst  in  1  synchronous active-high reset.
- xt_lb  in  lb_slave_t  LBUS slave bundle; uses addr[3:0] and wdata[7:0].
- wsel  in  1  write strobe for this slave, one cycle per write.
- rdata  out  8  combinational read data for xt_lb.addr.
- seg  out  8  segment lines, bit7 = dp, bits[6:0] = g..a; polarity per COM.
- com  out  NUM  digit select lines, one-hot active or all inactive.

Behaviour:
- One clock, lb_clk. Reset is synchronous and active-high on rst.
- Address map (addr[3:0]):
  - 0..NUM-1: DIG[i] (RW).
  - 8: CTRL (RW). bit0 EN, bit1 DEC (1 = bits[3:0] are hex and get decoded, bit7 = dp; 0 = raw segment bits), bit2 BLK_EN.
  - 9: DIV_LO (RW). 10: DIV_HI (RW).
  - 11: STAT (RO) = {4'b0, busy, idx[2:0]}.
  - Unmapped addresses and DIG[NUM..7]: writes ignored, reads return 0.
- Register writes take effect on the lb_clk edge where wsel = 1.
- Reset values:
  - All DIG = 0. CTRL = 0. DIV = 16'd999. idx = 0. FSM = IDLE.
  - seg all inactive: 8'h00 when COM = 0, 8'hFF when COM = 1.
  - com all inactive. These are also the outputs whenever the FSM is in IDLE or BLANK.
- FSM states: IDLE, ON, BLANK.
  - IDLE: when EN = 1, go to ON next cycle with idx = 0. Load seg from the DIG[0] pattern, assert com[0], load cnt = DIV.
  - ON: decrement cnt each cycle. When cnt == 0: go to BLANK if BLK_EN = 1 (load bcnt = BLANK_CYC-1), else go straight to ON for the next idx. The digit is therefore lit for exactly DIV+1 cycles.
  - BLANK: seg and com inactive. When bcnt == 0, go to ON for the next idx.
  - Next idx = (idx == NUM-1) ? 0 : idx+1.
- Tearing rule: seg is captured from DIG[idx] and CTRL.DEC on entry to ON. Writes to the digit currently lit show on its next visit. DIV is sampled only at the ON reload, so a mid-period write does not disturb the current count.
- EN cleared in any state: FSM goes to IDLE on the next edge, and seg/com go inactive on that edge. Re-enable restarts at idx 0.
- DIV = 0 lights each digit for 1 cycle (legal).
- NUM = 1: idx stays 0; the ON/BLANK cycle still runs.
- rst asserted mid-scan: all state returns to reset values on that edge, with no partial digit.
- A write and a scan event in the same cycle do not interact beyond the capture rule above.
- Pattern source: if DEC = 1, use the decoder output for hex 0..F with dp = DIG[i][7]; otherwise use DIG[i] raw. Apply inversion for COM = 1 last.
- busy = (FSM != IDLE).

Decomposition:
- Package ledsd_scan_pkg holds:
  - address constants ADDR_DIG0 = 0, ADDR_CTRL = 8, ADDR_DIVL = 9, ADDR_DIVH = 10, ADDR_STAT = 11;
  - a packed ctrl_t {blk_en, dec, en};
  - the state enum scan_state_e {IDLE, ON, BLANK}.
- Sub-module ledsd_hex_decode: combinational 4-bit to 7-segment, active-high, shared with other display blocks.

Test Plan:
- Reset, then read all addresses -> DIV_LO = 8'hE7, DIV_HI = 8'h03, CTRL = 0, STAT = 0; seg = 8'h00, com = 4'b1111 (COM = 0, NUM = 4).
- Write DIG0..3 = 8'h01,8'h02,8'h03,8'h84; DIV = 3; CTRL = 8'h07 -> com[0] low for 4 cycles with seg = 8'h06, then 4 blank cycles, then com[1] with seg = 8'h5B; digit 3 seg = 8'hE6; wraps to com[0] after digit 3.
- Same setup with BLK_EN = 0 -> digits back-to-back, period 16 cycles, never all-off between digits.
- Write DIG[idx] while that digit is lit -> seg unchanged until its next ON entry. Write DIV = 7 mid-ON -> current period still 4 cycles, next one 8 cycles.
- Clear EN mid-ON at idx 2 -> next edge seg = 8'h00, com = 4'b1111, STAT.busy = 0. Re-enable -> first lit digit is com[0].
- Assert rst mid-BLANK -> outputs and registers at reset values next edge. Write to addr 5 (NUM = 4) and addr 12 -> ignored, read back 0.

Source files
------------

// File: rtl/ledsd_scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment LBUS slave.
package ledsd_scan_pkg;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] wdata;
    } lb_slave_t;

    localparam logic [3:0] ADDR_DIG0 = 4'd0;
    localparam logic [3:0] ADDR_CTRL = 4'd8;
    localparam logic [3:0] ADDR_DIVL = 4'd9;
    localparam logic [3:0] ADDR_DIVH = 4'd10;
    localparam logic [3:0] ADDR_STAT = 4'd11;

    localparam logic [15:0] DIV_RESET = 16'd999;

    typedef struct packed {
        logic blk_en;
        logic dec;
        logic en;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        BLANK
    } scan_state_e;

    function automatic logic [2:0] next_idx(input logic [2:0] idx, input int unsigned num);
        return ({29'd0, idx} == num - 1) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/ledsd_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern, bits[6:0] = g..a.
module ledsd_hex_decode (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/ledsd_scan_lbus.sv
// LBUS slave scanning NUM seven-segment digits over a shared segment bus,
// with per-digit registers, a prescaler and an optional inter-digit blanking gap.
module ledsd_scan_lbus
    import ledsd_scan_pkg::*;
#(
    parameter int NUM       = 4,
    parameter int COM       = 0,
    parameter int BLANK_CYC = 4
) (
    input  logic            lb_clk,
    input  logic            rst,
    input  lb_slave_t       xt_lb,
    input  logic            wsel,
    output logic [7:0]      rdata,
    output logic [7:0]      seg,
    output logic [NUM-1:0]  com
);

    localparam logic [7:0]     SEG_OFF = {8{COM != 0}};
    localparam logic [NUM-1:0] COM_OFF = {NUM{COM == 0}};

    logic [7:0]   dig [NUM];
    ctrl_t        ctrl;
    logic [15:0]  div;

    scan_state_e  state, state_n;
    logic [2:0]   idx, idx_n;
    logic [15:0]  cnt, cnt_n;
    logic [15:0]  bcnt, bcnt_n;
    logic [7:0]   seg_n;
    logic [NUM-1:0] com_n;

    logic [2:0]   cap_idx;
    logic [7:0]   cap_dig;
    logic [6:0]   dec_seg;
    logic [7:0]   pattern;
    logic [7:0]   lit_seg;
    logic [NUM-1:0] com_act;
    logic [NUM-1:0] lit_com;

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                dig[i] <= '0;
            end
            ctrl <= '0;
            div  <= DIV_RESET;
        end else if (wsel) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                if (xt_lb.addr == ADDR_DIG0 + 4'(i)) begin
                    dig[i] <= xt_lb.wdata;
                end
            end
            case (xt_lb.addr)
                ADDR_CTRL: ctrl      <= ctrl_t'(xt_lb.wdata[2:0]);
                ADDR_DIVL: div[7:0]  <= xt_lb.wdata;
                ADDR_DIVH: div[15:8] <= xt_lb.wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            if (xt_lb.addr == ADDR_DIG0 + 4'(i)) begin
                rdata = dig[i];
            end
        end
        case (xt_lb.addr)
            ADDR_CTRL: rdata = {5'b0, ctrl};
            ADDR_DIVL: rdata = div[7:0];
            ADDR_DIVH: rdata = div[15:8];
            ADDR_STAT: rdata = {4'b0, state != IDLE, idx};
            default: ;
        endcase
    end

    // The digit pattern is latched only when ON is entered, so this path always
    // looks at the digit that would be lit next rather than the one lit now.
    always_comb begin
        cap_idx = (state == IDLE) ? 3'd0 : next_idx(idx, NUM);
        cap_dig = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            if (cap_idx == 3'(i)) begin
                cap_dig = dig[i];
            end
        end
    end

    ledsd_hex_decode u_hex_decode (
        .hex (cap_dig[3:0]),
        .seg (dec_seg)
    );

    always_comb begin
        pattern = ctrl.dec ? {cap_dig[7], dec_seg} : cap_dig;
        lit_seg = (COM != 0) ? ~pattern : pattern;
        com_act = NUM'(1) << cap_idx;
        lit_com = (COM != 0) ? com_act : ~com_act;
    end

    always_ff @(posedge lb_clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            bcnt  <= '0;
            seg   <= SEG_OFF;
            com   <= COM_OFF;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            bcnt  <= bcnt_n;
            seg   <= seg_n;
            com   <= com_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        bcnt_n  = bcnt;
        seg_n   = seg;
        com_n   = com;
        if (!ctrl.en) begin
            state_n = IDLE;
            idx_n   = '0;
            seg_n   = SEG_OFF;
            com_n   = COM_OFF;
        end else begin
            case (state)
                IDLE: begin
                    state_n = ON;
                    idx_n   = cap_idx;
                    cnt_n   = div;
                    seg_n   = lit_seg;
                    com_n   = lit_com;
                end
                ON: begin
                    if (cnt == '0) begin
                        if (ctrl.blk_en) begin
                            state_n = BLANK;
                            bcnt_n  = 16'(BLANK_CYC - 1);
                            seg_n   = SEG_OFF;
                            com_n   = COM_OFF;
                        end else begin
                            idx_n = cap_idx;
                            cnt_n = div;
                            seg_n = lit_seg;
                            com_n = lit_com;
                        end
                    end else begin
                        cnt_n = cnt - 16'd1;
                    end
                end
                BLANK: begin
                    if (bcnt == '0) begin
                        state_n = ON;
                        idx_n   = cap_idx;
                        cnt_n   = div;
                        seg_n   = lit_seg;
                        com_n   = lit_com;
                    end else begin
                        bcnt_n = bcnt - 16'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ledsd_scan_lbus.sv
// Bench for ledsd_scan_lbus: slot-schedule reference model compared every cycle,
// plus directed register and timing checks with literal expectations.
module tb_ledsd_scan_lbus;
    import ledsd_scan_pkg::*;

    localparam int NUM       = 4;
    localparam int COM       = 0;
    localparam int BLANK_CYC = 4;

    logic            lb_clk = 1'b0;
    logic            rst    = 1'b1;
    logic            wsel   = 1'b0;
    lb_slave_t       xt_lb  = '0;
    logic [7:0]      rdata;
    logic [7:0]      seg;
    logic [NUM-1:0]  com;

    ledsd_scan_lbus #(
        .NUM       (NUM),
        .COM       (COM),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .lb_clk (lb_clk),
        .rst    (rst),
        .xt_lb  (xt_lb),
        .wsel   (wsel),
        .rdata  (rdata),
        .seg    (seg),
        .com    (com)
    );

    always #5 lb_clk = ~lb_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers plus a schedule of lit/gap slots.
    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0]  m_dig [NUM];
    logic [2:0]  m_ctrl;
    logic [15:0] m_div;
    bit          m_active;
    bit          m_lit;
    int          m_digit;
    int          m_left;
    logic [7:0]  m_pat;
    bit          cmp_on = 1'b0;

    function automatic logic [7:0] m_pattern(input int d);
        logic [7:0] v;
        v = m_dig[d];
        return m_ctrl[1] ? {v[7], hex_tab[v[3:0]]} : v;
    endfunction

    function automatic logic [7:0] exp_seg();
        return (m_active && m_lit) ? m_pat : 8'h00;
    endfunction

    function automatic logic [NUM-1:0] exp_com();
        return (m_active && m_lit) ? ~(4'b0001 << m_digit) : 4'b1111;
    endfunction

    function automatic logic [7:0] m_read(input int a);
        if (a < NUM) return m_dig[a];
        case (a)
            8:  return {5'b0, m_ctrl};
            9:  return m_div[7:0];
            10: return m_div[15:8];
            11: return {4'b0, m_active, 3'(m_digit)};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge lb_clk) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) m_dig[i] = 8'h00;
            m_ctrl   = 3'b000;
            m_div    = 16'd999;
            m_active = 1'b0;
            m_lit    = 1'b0;
            m_digit  = 0;
            m_left   = 0;
            m_pat    = 8'h00;
        end else begin
            if (!m_ctrl[0]) begin
                m_active = 1'b0;
                m_lit    = 1'b0;
                m_digit  = 0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_lit    = 1'b1;
                m_digit  = 0;
                m_left   = int'(m_div) + 1;
                m_pat    = m_pattern(0);
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lit && m_ctrl[2]) begin
                        m_lit  = 1'b0;
                        m_left = BLANK_CYC;
                    end else begin
                        m_digit = (m_digit + 1) % NUM;
                        m_lit   = 1'b1;
                        m_left  = int'(m_div) + 1;
                        m_pat   = m_pattern(m_digit);
                    end
                end
            end
            if (wsel) begin
                if (int'(xt_lb.addr) < NUM) m_dig[int'(xt_lb.addr)] = xt_lb.wdata;
                else if (xt_lb.addr == 4'd8)  m_ctrl = xt_lb.wdata[2:0];
                else if (xt_lb.addr == 4'd9)  m_div[7:0] = xt_lb.wdata;
                else if (xt_lb.addr == 4'd10) m_div[15:8] = xt_lb.wdata;
            end
        end
    end

    always @(negedge lb_clk) begin
        if (cmp_on) begin
            check("model_seg", 32'(seg), 32'(exp_seg()));
            check("model_com", 32'(com), 32'(exp_com()));
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        xt_lb.addr  = a;
        xt_lb.wdata = d;
        wsel        = 1'b1;
        @(negedge lb_clk);
        wsel        = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input string name);
        xt_lb.addr = a;
        #1;
        check(name, 32'(rdata), 32'(m_read(int'(a))));
        @(negedge lb_clk);
    endtask

    task automatic read_lit(input logic [3:0] a, input logic [7:0] exp, input string name);
        xt_lb.addr = a;
        #1;
        check(name, 32'(rdata), 32'(exp));
        @(negedge lb_clk);
    endtask

    task automatic wait_start(input logic [NUM-1:0] c, input string name);
        logic [NUM-1:0] prev;
        int k;
        prev = com;
        for (k = 0; k < 200; k++) begin
            @(negedge lb_clk);
            if (com == c && prev != c) break;
            prev = com;
        end
        n_checks++;
        if (k == 200) begin
            n_errors++;
            $display("FAIL %s: timeout waiting for com=%b, got %b", name, c, com);
        end
    endtask

    task automatic run_len(input logic [NUM-1:0] c, output int n);
        n = 0;
        while (com == c && n < 100) begin
            n++;
            @(negedge lb_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int off_cnt;
        int k;
        rst = 1'b1;
        @(negedge lb_clk);
        cmp_on = 1'b1;
        repeat (2) @(negedge lb_clk);
        rst = 1'b0;

        // Reset state
        read_lit(4'd9,  8'hE7, "rst_div_lo");
        read_lit(4'd10, 8'h03, "rst_div_hi");
        read_lit(4'd8,  8'h00, "rst_ctrl");
        read_lit(4'd11, 8'h00, "rst_stat");
        check("rst_seg", 32'(seg), 32'h00);
        check("rst_com", 32'(com), 32'hF);
        for (int a = 0; a < 16; a++) bus_read(4'(a), "rst_map");

        // Decoded scan with blanking
        bus_write(4'd0, 8'h01);
        bus_write(4'd1, 8'h02);
        bus_write(4'd2, 8'h03);
        bus_write(4'd3, 8'h84);
        bus_write(4'd9, 8'h03);
        bus_write(4'd10, 8'h00);
        bus_write(4'd8, 8'h07);
        wait_start(4'b1110, "d0_start");
        check("d0_seg", 32'(seg), 32'h06);
        run_len(4'b1110, n);
        check("d0_len", 32'(n), 32'd4);
        run_len(4'b1111, n);
        check("blank_len", 32'(n), 32'd4);
        check("d1_com", 32'(com), 32'hD);
        check("d1_seg", 32'(seg), 32'h5B);
        wait_start(4'b0111, "d3_start");
        check("d3_seg", 32'(seg), 32'hE6);
        run_len(4'b0111, n);
        run_len(4'b1111, n);
        check("wrap_com", 32'(com), 32'hE);

        // Back-to-back digits
        bus_write(4'd8, 8'h03);
        wait_start(4'b1110, "nb_start");
        off_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (com == 4'b1111) off_cnt++;
            @(negedge lb_clk);
        end
        check("nb_gaps", 32'(off_cnt), 32'd0);
        check("nb_period", 32'(com), 32'hE);

        // Tearing: write to the lit digit holds until its next visit
        wait_start(4'b1110, "tear_start");
        bus_write(4'd0, 8'h07);
        check("tear_hold", 32'(seg), 32'h06);
        wait_start(4'b1110, "tear_next");
        check("tear_new", 32'(seg), 32'h07);

        // DIV written mid-period
        wait_start(4'b1101, "div_start");
        bus_write(4'd9, 8'h07);
        run_len(4'b1101, n);
        check("div_cur_len", 32'(n + 1), 32'd4);
        wait_start(4'b1101, "div_next");
        run_len(4'b1101, n);
        check("div_next_len", 32'(n), 32'd8);

        // EN cleared while digit 2 is lit
        wait_start(4'b1011, "en_start");
        bus_write(4'd8, 8'h02);
        @(negedge lb_clk);
        check("en_off_seg", 32'(seg), 32'h00);
        check("en_off_com", 32'(com), 32'hF);
        read_lit(4'd11, 8'h00, "en_off_stat");
        bus_write(4'd8, 8'h07);
        for (k = 0; k < 50 && com == 4'b1111; k++) @(negedge lb_clk);
        check("reen_first", 32'(com), 32'hE);

        // Reset during blanking gap
        wait_start(4'b1111, "blank_start");
        rst = 1'b1;
        @(negedge lb_clk);
        rst = 1'b0;
        check("rst2_seg", 32'(seg), 32'h00);
        check("rst2_com", 32'(com), 32'hF);
        read_lit(4'd9,  8'hE7, "rst2_div_lo");
        read_lit(4'd10, 8'h03, "rst2_div_hi");
        read_lit(4'd8,  8'h00, "rst2_ctrl");
        read_lit(4'd11, 8'h00, "rst2_stat");
        read_lit(4'd0,  8'h00, "rst2_dig0");

        // Unmapped writes
        bus_write(4'd5, 8'hAA);
        bus_write(4'd12, 8'h55);
        read_lit(4'd5,  8'h00, "unmapped_5");
        read_lit(4'd12, 8'h00, "unmapped_12");

        // DIV = 0, raw patterns, no blanking
        bus_write(4'd9, 8'h00);
        bus_write(4'd10, 8'h00);
        bus_write(4'd0, 8'h3F);
        bus_write(4'd1, 8'h80);
        bus_write(4'd8, 8'h01);
        wait_start(4'b1110, "div0_start");
        check("raw_seg", 32'(seg), 32'h3F);
        @(negedge lb_clk);
        check("div0_next_com", 32'(com), 32'hD);
        check("div0_next_seg", 32'(seg), 32'h80);
        repeat (12) @(negedge lb_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
